noc_credit_link: RTL and testbench

Bundle of credit-flow-controlled, optionally pipelined router-to-router output links for the NoC. Each link sits between one router output port and the neighbouring router's input buffer. It holds a per-port credit counter sized to the downstream flit buffer, exposes a valid/ready handshake to the router side, and drives the `send`/`credit` wire protocol on the link side. It inserts `NUM_PIPELINE` register stages on both the forward (flit) path and the reverse (credit) path.

---
 rtl/noc_credit_link_if.sv | 42 ++++
 rtl/noc_credit_link.sv | 147 ++++++++++++++
 tb/tb_noc_credit_link.sv | 322 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/noc_credit_link_if.sv
// ============================================================================
// Module      : noc_credit_link_if
// Description : Router-side valid/ready handshake and link-side send/credit
//               wires for a bundle of NUM_LINKS credit-flow-controlled links.
//               master : router + downstream neighbour (drives flits in and
//                        credits back, observes the link outputs)
//               slave  : noc_credit_link
// Signals     : in_valid/in_ready/in_data/in_dest/in_is_tail  router side
//               data_out/dest_out/is_tail_out/send_out        link forward
//               credit_in                                     link reverse
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface noc_credit_link_if #(
  parameter int NUM_LINKS  = 4,
  parameter int FLIT_WIDTH = 128,
  parameter int DEST_WIDTH = 6
);
  logic [0:NUM_LINKS-1]  in_valid;
  logic [0:NUM_LINKS-1]  in_ready;
  logic [FLIT_WIDTH-1:0] in_data     [0:NUM_LINKS-1];
  logic [DEST_WIDTH-1:0] in_dest     [0:NUM_LINKS-1];
  logic [0:NUM_LINKS-1]  in_is_tail;
  logic [FLIT_WIDTH-1:0] data_out    [0:NUM_LINKS-1];
  logic [DEST_WIDTH-1:0] dest_out    [0:NUM_LINKS-1];
  logic [0:NUM_LINKS-1]  is_tail_out;
  logic [0:NUM_LINKS-1]  send_out;
  logic [0:NUM_LINKS-1]  credit_in;

  modport master (
    output in_valid, in_data, in_dest, in_is_tail, credit_in,
    input  in_ready, data_out, dest_out, is_tail_out, send_out
  );

  modport slave (
    input  in_valid, in_data, in_dest, in_is_tail, credit_in,
    output in_ready, data_out, dest_out, is_tail_out, send_out
  );
endinterface

`default_nettype wire

// File: rtl/noc_credit_link.sv
// ============================================================================
// Module      : noc_credit_link
// Description : NUM_LINKS independent credit-flow-controlled router-to-router
//               output links with NUM_PIPELINE register stages on both the
//               forward (flit) and reverse (credit) paths.
// Ports       : clk_noc       NoC clock
//               rst_n         asynchronous active-low reset
//               lnk           noc_credit_link_if.slave (handshake + link wires)
//               credit_avail  per-link credit count (CW bits)
//               err_overflow  per-link sticky credit-overflow flag
//               flit_count    per-link accepted flits   (STATS build only)
//               pkt_count     per-link accepted packets (STATS build only)
// Options     : define NOC_CREDIT_LINK_STATS_EN to add flit/packet counters.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module noc_credit_link #(
  parameter int NUM_LINKS         = 4,
  parameter int FLIT_WIDTH        = 128,
  parameter int DEST_WIDTH        = 6,
  parameter int FLIT_BUFFER_DEPTH = 1,
  parameter int NUM_PIPELINE      = 0,
  localparam int CW               = $clog2(FLIT_BUFFER_DEPTH + 1)
) (
  input  wire logic            clk_noc,
  input  wire logic            rst_n,
  noc_credit_link_if.slave     lnk,
  output logic [CW-1:0]        credit_avail [0:NUM_LINKS-1],
  output logic [0:NUM_LINKS-1] err_overflow
`ifdef NOC_CREDIT_LINK_STATS_EN
  ,
  output logic [31:0]          flit_count   [0:NUM_LINKS-1],
  output logic [31:0]          pkt_count    [0:NUM_LINKS-1]
`endif
);

  localparam logic [CW-1:0] c_depth = CW'(FLIT_BUFFER_DEPTH);

  for (genvar i = 0; i < NUM_LINKS; i++) begin : g_link
    logic [CW-1:0]         r_cnt;
    logic                  r_err;
    logic                  w_ready;
    logic                  w_hs;
    logic                  w_cret;
    // Stage 0 is the capture register; stage NUM_PIPELINE drives the link.
    logic                  r_send [0:NUM_PIPELINE];
    logic [FLIT_WIDTH-1:0] r_data [0:NUM_PIPELINE];
    logic [DEST_WIDTH-1:0] r_dest [0:NUM_PIPELINE];
    logic                  r_tail [0:NUM_PIPELINE];

    // Ready depends only on the credit count, never on in_valid.
    assign w_ready = (r_cnt != '0);
    assign w_hs    = lnk.in_valid[i] & w_ready;

    if (NUM_PIPELINE == 0) begin : g_cred_direct
      assign w_cret = lnk.credit_in[i];
    end else begin : g_cred_pipe
      logic [NUM_PIPELINE-1:0] r_cred;
      always_ff @(posedge clk_noc or negedge rst_n) begin
        if (!rst_n) begin
          r_cred <= '0;
        end else begin
          r_cred[0] <= lnk.credit_in[i];
          for (int k = 1; k < NUM_PIPELINE; k++) begin
            r_cred[k] <= r_cred[k-1];
          end
        end
      end
      assign w_cret = r_cred[NUM_PIPELINE-1];
    end

    // Forward path: send bits shift every cycle; payload only loads behind
    // a set send bit so idle stages do not toggle.
    always_ff @(posedge clk_noc or negedge rst_n) begin
      if (!rst_n) begin
        for (int k = 0; k <= NUM_PIPELINE; k++) begin
          r_send[k] <= 1'b0;
          r_data[k] <= '0;
          r_dest[k] <= '0;
          r_tail[k] <= 1'b0;
        end
      end else begin
        r_send[0] <= w_hs;
        if (w_hs) begin
          r_data[0] <= lnk.in_data[i];
          r_dest[0] <= lnk.in_dest[i];
          r_tail[0] <= lnk.in_is_tail[i];
        end
        for (int k = 1; k <= NUM_PIPELINE; k++) begin
          r_send[k] <= r_send[k-1];
          if (r_send[k-1]) begin
            r_data[k] <= r_data[k-1];
            r_dest[k] <= r_dest[k-1];
            r_tail[k] <= r_tail[k-1];
          end
        end
      end
    end

    // Credit counter: a simultaneous send and returned credit cancel out.
    // A returned credit at full count saturates and raises the sticky error.
    always_ff @(posedge clk_noc or negedge rst_n) begin
      if (!rst_n) begin
        r_cnt <= c_depth;
        r_err <= 1'b0;
      end else if (w_hs && !w_cret) begin
        r_cnt <= r_cnt - CW'(1);
      end else if (w_cret && !w_hs) begin
        if (r_cnt == c_depth) begin
          r_err <= 1'b1;
        end else begin
          r_cnt <= r_cnt + CW'(1);
        end
      end
    end

    assign lnk.in_ready[i]    = w_ready;
    assign lnk.send_out[i]    = r_send[NUM_PIPELINE];
    assign lnk.data_out[i]    = r_data[NUM_PIPELINE];
    assign lnk.dest_out[i]    = r_dest[NUM_PIPELINE];
    assign lnk.is_tail_out[i] = r_tail[NUM_PIPELINE];
    assign credit_avail[i]    = r_cnt;
    assign err_overflow[i]    = r_err;

`ifdef NOC_CREDIT_LINK_STATS_EN
    logic [31:0] r_flits;
    logic [31:0] r_pkts;
    always_ff @(posedge clk_noc or negedge rst_n) begin
      if (!rst_n) begin
        r_flits <= '0;
        r_pkts  <= '0;
      end else if (w_hs) begin
        r_flits <= r_flits + 32'd1;
        if (lnk.in_is_tail[i]) begin
          r_pkts <= r_pkts + 32'd1;
        end
      end
    end
    assign flit_count[i] = r_flits;
    assign pkt_count[i]  = r_pkts;
`endif
  end : g_link

endmodule

`default_nettype wire

// File: tb/tb_noc_credit_link.sv
// ============================================================================
// Module      : tb_noc_credit_link
// Description : Self-checking bench for noc_credit_link (4 links, depth 2,
//               one pipeline stage). A queue-based reference model predicts
//               flit arrival cycles, credit counts and overflow flags.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_noc_credit_link;
  localparam int NL    = 4;
  localparam int FW    = 32;
  localparam int DW    = 6;
  localparam int DEPTH = 2;
  localparam int NP    = 1;
  localparam int CW    = $clog2(DEPTH + 1);

  logic clk_noc = 1'b0;
  logic rst_n;
  always #5 clk_noc = ~clk_noc;

  noc_credit_link_if #(.NUM_LINKS(NL), .FLIT_WIDTH(FW), .DEST_WIDTH(DW)) lnk ();
  logic [CW-1:0] credit_avail [0:NL-1];
  logic [0:NL-1] err_overflow;
`ifdef NOC_CREDIT_LINK_STATS_EN
  logic [31:0]   flit_count [0:NL-1];
  logic [31:0]   pkt_count  [0:NL-1];
`endif

  noc_credit_link #(
    .NUM_LINKS(NL), .FLIT_WIDTH(FW), .DEST_WIDTH(DW),
    .FLIT_BUFFER_DEPTH(DEPTH), .NUM_PIPELINE(NP)
  ) dut (
    .clk_noc(clk_noc),
    .rst_n(rst_n),
    .lnk(lnk),
    .credit_avail(credit_avail),
    .err_overflow(err_overflow)
`ifdef NOC_CREDIT_LINK_STATS_EN
    ,
    .flit_count(flit_count),
    .pkt_count(pkt_count)
`endif
  );

  typedef struct {
    int            due;
    logic [FW-1:0] data;
    logic [DW-1:0] dest;
    logic          tail;
  } flit_t;

  // Reference model state
  flit_t       fq [NL][$];   // flits in flight, with the cycle they appear
  int          cq [NL][$];   // credits in flight, with the cycle they apply
  int          m_cred [NL];
  bit          m_err  [NL];
  bit          m_hs   [NL];
  int          held   [NL];  // flits sitting in the modelled downstream buffer
  int unsigned m_flits [NL];
  int unsigned m_pkts  [NL];

  // Stimulus for the current cycle
  logic          d_valid  [NL];
  logic          d_tail   [NL];
  logic          d_credit [NL];
  logic [FW-1:0] d_data   [NL];
  logic [DW-1:0] d_dest   [NL];

  int cyc;
  int n_chk;
  int n_fail;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  function automatic void model_reset();
    for (int l = 0; l < NL; l++) begin
      fq[l].delete();
      cq[l].delete();
      m_cred[l]  = DEPTH;
      m_err[l]   = 1'b0;
      m_hs[l]    = 1'b0;
      held[l]    = 0;
      m_flits[l] = 0;
      m_pkts[l]  = 0;
      d_valid[l] = 1'b0;
      d_tail[l]  = 1'b0;
      d_credit[l] = 1'b0;
      d_data[l]  = '0;
      d_dest[l]  = '0;
    end
  endfunction

  task automatic drive_dut();
    for (int l = 0; l < NL; l++) begin
      lnk.in_valid[l]   = d_valid[l];
      lnk.in_data[l]    = d_data[l];
      lnk.in_dest[l]    = d_dest[l];
      lnk.in_is_tail[l] = d_tail[l];
      lnk.credit_in[l]  = d_credit[l];
    end
  endtask

  task automatic check_outputs();
    flit_t f;
    for (int l = 0; l < NL; l++) begin
      if (fq[l].size() != 0 && fq[l][0].due == cyc) begin
        f = fq[l].pop_front();
        check($sformatf("send_out[%0d]", l), 64'(lnk.send_out[l]), 64'd1);
        check($sformatf("data_out[%0d]", l), 64'(lnk.data_out[l]), 64'(f.data));
        check($sformatf("dest_out[%0d]", l), 64'(lnk.dest_out[l]), 64'(f.dest));
        check($sformatf("is_tail_out[%0d]", l), 64'(lnk.is_tail_out[l]), 64'(f.tail));
        held[l]++;
      end else begin
        check($sformatf("send_out_idle[%0d]", l), 64'(lnk.send_out[l]), 64'd0);
      end
      check($sformatf("credit_avail[%0d]", l), 64'(credit_avail[l]), 64'(m_cred[l]));
      check($sformatf("in_ready[%0d]", l), 64'(lnk.in_ready[l]), 64'(m_cred[l] != 0));
      check($sformatf("err_overflow[%0d]", l), 64'(err_overflow[l]), 64'(m_err[l]));
`ifdef NOC_CREDIT_LINK_STATS_EN
      check($sformatf("flit_count[%0d]", l), 64'(flit_count[l]), 64'(m_flits[l]));
      check($sformatf("pkt_count[%0d]", l), 64'(pkt_count[l]), 64'(m_pkts[l]));
`endif
    end
  endtask

  // One clock cycle: apply stimulus, advance the model across the edge,
  // then compare the DUT against the model just after the edge.
  task automatic step();
    bit ret;
    drive_dut();
    @(posedge clk_noc);
    for (int l = 0; l < NL; l++) begin
      m_hs[l] = d_valid[l] && (m_cred[l] != 0);
      if (d_credit[l]) cq[l].push_back(cyc + NP);
      ret = (cq[l].size() != 0) && (cq[l][0] == cyc);
      if (ret) void'(cq[l].pop_front());
      if (m_hs[l]) begin
        fq[l].push_back('{cyc + 1 + NP, d_data[l], d_dest[l], d_tail[l]});
        m_flits[l]++;
        if (d_tail[l]) m_pkts[l]++;
      end
      if (m_hs[l] && !ret) begin
        m_cred[l]--;
      end else if (ret && !m_hs[l]) begin
        if (m_cred[l] == DEPTH) m_err[l] = 1'b1;
        else m_cred[l]++;
      end
    end
    cyc++;
    #1;
    check_outputs();
  endtask

  // Downstream neighbour frees buffered flits at a link-dependent rate.
  task automatic downstream_credits(input bit enable);
    for (int l = 0; l < NL; l++) begin
      d_credit[l] = enable && (held[l] > 0) && ($urandom_range(0, l + 1) == 0);
      if (d_credit[l]) held[l]--;
    end
  endtask

  // Asynchronous reset asserted mid-cycle; outputs must clear at once.
  task automatic reset_mid_cycle();
    #3 rst_n = 1'b0;
    #1;
    for (int l = 0; l < NL; l++) begin
      check($sformatf("rst_send_out[%0d]", l), 64'(lnk.send_out[l]), 64'd0);
      check($sformatf("rst_data_out[%0d]", l), 64'(lnk.data_out[l]), 64'd0);
      check($sformatf("rst_credit_avail[%0d]", l), 64'(credit_avail[l]), 64'(DEPTH));
      check($sformatf("rst_in_ready[%0d]", l), 64'(lnk.in_ready[l]), 64'd1);
      check($sformatf("rst_err_overflow[%0d]", l), 64'(err_overflow[l]), 64'd0);
`ifdef NOC_CREDIT_LINK_STATS_EN
      check($sformatf("rst_flit_count[%0d]", l), 64'(flit_count[l]), 64'd0);
      check($sformatf("rst_pkt_count[%0d]", l), 64'(pkt_count[l]), 64'd0);
`endif
    end
    model_reset();
    drive_dut();
    @(negedge clk_noc);
    rst_n = 1'b1;
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    cyc    = 0;
    rst_n  = 1'b0;
    model_reset();
    drive_dut();

    // Reset state
    repeat (3) @(posedge clk_noc);
    #1;
    for (int l = 0; l < NL; l++) begin
      check($sformatf("reset_credit_avail[%0d]", l), 64'(credit_avail[l]), 64'(DEPTH));
      check($sformatf("reset_in_ready[%0d]", l), 64'(lnk.in_ready[l]), 64'd1);
      check($sformatf("reset_send_out[%0d]", l), 64'(lnk.send_out[l]), 64'd0);
      check($sformatf("reset_data_out[%0d]", l), 64'(lnk.data_out[l]), 64'd0);
      check($sformatf("reset_dest_out[%0d]", l), 64'(lnk.dest_out[l]), 64'd0);
      check($sformatf("reset_tail_out[%0d]", l), 64'(lnk.is_tail_out[l]), 64'd0);
      check($sformatf("reset_err[%0d]", l), 64'(err_overflow[l]), 64'd0);
    end
    @(negedge clk_noc);
    rst_n = 1'b1;

    // Link 0: valid for three cycles with no credits back -> two accepted
    for (int k = 0; k < 3; k++) begin
      d_valid[0] = 1'b1;
      d_data[0]  = FW'($urandom);
      d_dest[0]  = DW'($urandom);
      d_tail[0]  = (k == 1);
      if (k == 2) check("in_ready_exhausted", 64'(lnk.in_ready[0]), 64'd0);
      step();
    end
    d_valid[0] = 1'b0;
    repeat (3) step();
    check("credits_spent", 64'(credit_avail[0]), 64'd0);

    // Handshake and returned credit in the same cycle at count 1
    d_credit[0] = 1'b1; held[0]--; step();
    d_credit[0] = 1'b0; step();
    d_credit[0] = 1'b1; held[0]--; step();
    check("count_one_before", 64'(credit_avail[0]), 64'd1);
    d_credit[0] = 1'b0;
    d_valid[0]  = 1'b1;
    d_data[0]   = FW'($urandom);
    d_dest[0]   = DW'($urandom);
    step();
    d_valid[0]  = 1'b0;
    check("count_one_held", 64'(credit_avail[0]), 64'd1);
    check("ready_one_held", 64'(lnk.in_ready[0]), 64'd1);
    repeat (2) step();
    d_credit[0] = 1'b1; held[0]--; step();
    d_credit[0] = 1'b0;
    repeat (2) step();
    check("count_refilled", 64'(credit_avail[0]), 64'd2);

    // Extra credit at full count: saturate and flag
    d_credit[0] = 1'b1; step();
    d_credit[0] = 1'b0;
    repeat (2) step();
    check("overflow_count", 64'(credit_avail[0]), 64'd2);
    check("overflow_flag", 64'(err_overflow[0]), 64'd1);
    repeat (5) step();
    check("overflow_sticky", 64'(err_overflow[0]), 64'd1);

    // All links streaming with staggered downstream credit returns
    for (int c = 0; c < 400; c++) begin
      for (int l = 0; l < NL; l++) begin
        d_valid[l] = ($urandom_range(0, 3) != 0);
        d_data[l]  = FW'($urandom);
        d_dest[l]  = DW'($urandom);
        d_tail[l]  = ($urandom_range(0, 3) == 0);
      end
      downstream_credits(1'b1);
      step();
    end
    for (int c = 0; c < 40; c++) begin
      for (int l = 0; l < NL; l++) d_valid[l] = 1'b0;
      downstream_credits(1'b1);
      step();
    end

    // Mid-stream reset
    for (int l = 0; l < NL; l++) begin
      d_valid[l] = 1'b1;
      d_data[l]  = FW'($urandom);
    end
    downstream_credits(1'b0);
    repeat (2) step();
    reset_mid_cycle();

`ifdef NOC_CREDIT_LINK_STATS_EN
    // Three 4-flit packets on link 2
    begin
      int sent;
      int budget;
      sent   = 0;
      budget = 0;
      while (sent < 12 && budget < 300) begin
        d_valid[2] = 1'b1;
        d_tail[2]  = ((sent % 4) == 3);
        d_data[2]  = FW'($urandom);
        d_dest[2]  = DW'($urandom);
        downstream_credits(1'b1);
        step();
        if (m_hs[2]) sent++;
        budget++;
      end
      check("stats_flits_sent", 64'(sent), 64'd12);
      d_valid[2] = 1'b0;
      repeat (4) begin
        downstream_credits(1'b1);
        step();
      end
      check("flit_count_link2", 64'(flit_count[2]), 64'd12);
      check("pkt_count_link2", 64'(pkt_count[2]), 64'd3);
      check("flit_count_link0", 64'(flit_count[0]), 64'd0);
      check("pkt_count_link3", 64'(pkt_count[3]), 64'd0);
      // Reset in the middle of a packet
      d_valid[2] = 1'b1;
      d_tail[2]  = 1'b0;
      downstream_credits(1'b0);
      repeat (2) step();
      reset_mid_cycle();
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
